// File: rtl/wam_pkg.sv
// Shared constants for the Whac-A-Mole session controller: state encoding and BCD widths.
package wam_pkg;

    localparam int BCD_W   = 4;
    localparam int SCORE_W = 12;

    typedef enum logic [1:0] {
        WAM_IDLE  = 2'd0,
        WAM_RUN   = 2'd1,
        WAM_PAUSE = 2'd2,
        WAM_OVER  = 2'd3
    } wam_state_t;

endpackage

// File: rtl/wam_dbn.sv
// Button conditioner: 2-flop synchronizer, stable-count debounce, and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module wam_dbn #(
    parameter int DB_CYC = 500_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn,
    output logic press
);

    localparam int              CNT_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYC - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so short glitches never get through.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wam_ctl.sv
// Game-session controller: debounced buttons, IDLE/RUN/PAUSE/OVER FSM, gated game tick,
// BCD round countdown and best-score latch.
module wam_ctl
    import wam_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 100,
    parameter int GAME_SEC = 60,
    parameter int DB_CYC   = 500_000
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               btn_go,
    input  logic               btn_clr,
    input  logic [SCORE_W-1:0] score,
    output logic               tick,
    output logic               run,
    output logic               game_over,
    output logic               soft_clr,
    output logic [2*BCD_W-1:0] time_bcd,
    output logic [SCORE_W-1:0] best_bcd,
    output logic [1:0]         state
);

    localparam int               DIV     = CLK_HZ / TICK_HZ;
    localparam int               DIV_W   = $clog2(DIV);
    localparam int               SEC_W   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(TICK_HZ - 1);
    localparam logic [2*BCD_W-1:0] TIME_INIT = {BCD_W'(GAME_SEC / 10), BCD_W'(GAME_SEC % 10)};
    localparam logic [2*BCD_W-1:0] TIME_LAST = {BCD_W'(0), BCD_W'(1)};

    function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [2*BCD_W-1:0] t);
        if (t[BCD_W-1:0] == '0)
            return {t[2*BCD_W-1:BCD_W] - BCD_W'(1), BCD_W'(9)};
        else
            return {t[2*BCD_W-1:BCD_W], t[BCD_W-1:0] - BCD_W'(1)};
    endfunction

    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int d = SCORE_W / BCD_W - 1; d >= 0; d--) begin
            if (!done && (a[d*BCD_W +: BCD_W] != b[d*BCD_W +: BCD_W])) begin
                gt   = a[d*BCD_W +: BCD_W] > b[d*BCD_W +: BCD_W];
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    wam_state_t       st;
    wam_state_t       st_nxt;
    logic             soft_nxt;
    logic             go_p;
    logic             clr_p;
    logic [DIV_W-1:0] div_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             adv;
    logic             sec_wrap;
    logic             expire;

    wam_dbn #(.DB_CYC(DB_CYC)) u_dbn_go  (.clk(clk), .clr_n(clr_n), .btn(btn_go),  .press(go_p));
    wam_dbn #(.DB_CYC(DB_CYC)) u_dbn_clr (.clk(clk), .clr_n(clr_n), .btn(btn_clr), .press(clr_p));

    assign sec_wrap = tick && (sec_cnt == SEC_MAX);
    assign expire   = sec_wrap && (time_bcd == TIME_LAST);
    // The divider only advances across RUN->RUN edges, so a pause freezes it mid-count.
    assign adv      = (st == WAM_RUN) && (st_nxt == WAM_RUN);

    always_comb begin
        st_nxt   = st;
        soft_nxt = 1'b0;
        if (clr_p) begin
            st_nxt   = WAM_IDLE;
            soft_nxt = 1'b1;
        end else begin
            case (st)
                WAM_IDLE: if (go_p) begin
                    st_nxt   = WAM_RUN;
                    soft_nxt = 1'b1;
                end
                WAM_RUN: begin
                    if (expire)    st_nxt = WAM_OVER;
                    else if (go_p) st_nxt = WAM_PAUSE;
                end
                WAM_PAUSE: if (go_p) st_nxt = WAM_RUN;
                WAM_OVER:  if (go_p) st_nxt = WAM_IDLE;
                default:   st_nxt = WAM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st       <= WAM_IDLE;
            soft_clr <= 1'b0;
            tick     <= 1'b0;
            div_cnt  <= '0;
            sec_cnt  <= '0;
            time_bcd <= TIME_INIT;
            best_bcd <= '0;
        end else begin
            st       <= st_nxt;
            soft_clr <= soft_nxt;
            tick     <= adv && (div_cnt == DIV_MAX);

            if (st_nxt == WAM_IDLE)
                div_cnt <= '0;
            else if (adv)
                div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);

            if (st_nxt == WAM_IDLE)
                sec_cnt <= '0;
            else if (tick)
                sec_cnt <= sec_wrap ? '0 : sec_cnt + SEC_W'(1);

            if (st_nxt == WAM_IDLE)
                time_bcd <= TIME_INIT;
            else if (sec_wrap)
                time_bcd <= bcd_dec(time_bcd);

            if ((st == WAM_RUN) && (st_nxt == WAM_OVER) && bcd_gt(score, best_bcd))
                best_bcd <= score;
        end
    end

    assign run       = (st == WAM_RUN);
    assign game_over = (st == WAM_OVER);
    assign state     = st;

endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl with a 100-cycle tick, 3-second rounds and a 4-cycle debounce.
module tb_wam_ctl;

    logic        clk;
    logic        clr_n;
    logic        btn_go;
    logic        btn_clr;
    logic [11:0] score;
    logic        tick;
    logic        run;
    logic        game_over;
    logic        soft_clr;
    logic [7:0]  time_bcd;
    logic [11:0] best_bcd;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int soft_cnt = 0;
    int pause_cnt = 0;

    wam_ctl #(
        .CLK_HZ(1000), .TICK_HZ(10), .GAME_SEC(3), .DB_CYC(4)
    ) dut (
        .clk(clk), .clr_n(clr_n), .btn_go(btn_go), .btn_clr(btn_clr), .score(score),
        .tick(tick), .run(run), .game_over(game_over), .soft_clr(soft_clr),
        .time_bcd(time_bcd), .best_bcd(best_bcd), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick) tick_cnt <= tick_cnt + 1;
        if (soft_clr) soft_cnt <= soft_cnt + 1;
        if (state == 2'd2) pause_cnt <= pause_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Holds btn_go for 8 cycles and waits until the debounced level has dropped again.
    // s is the cycle at which the resulting state change becomes visible.
    task automatic press_go(output int s);
        s = cyc + 7;
        btn_go = 1'b1;
        repeat (8) step();
        btn_go = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        clr_n = 1'b0; btn_go = 1'b0; btn_clr = 1'b0; score = 12'h000;
        repeat (3) step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %0b want 0", tick); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_run: got %0b want 0", run); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_over: got %0b want 0", game_over); end
        checks++; if (soft_clr !== 1'b0) begin errors++; $display("FAIL rst_soft: got %0b want 0", soft_clr); end
        checks++; if (time_bcd !== 8'h03) begin errors++; $display("FAIL rst_time: got %0h want 03", time_bcd); end
        checks++; if (best_bcd !== 12'h000) begin errors++; $display("FAIL rst_best: got %0h want 000", best_bcd); end
        clr_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_round();
        int c0, s, tc, sc;
        score = 12'h045;
        sc = soft_cnt;
        c0 = cyc;
        btn_go = 1'b1;
        step_to(c0 + 6);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_early: got %0d want 0", state); end
        step_to(c0 + 7);
        s = c0 + 7;
        tc = tick_cnt;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state); end
        checks++; if (soft_clr !== 1'b1) begin errors++; $display("FAIL start_soft: got %0b want 1", soft_clr); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_run: got %0b want 1", run); end
        step_to(c0 + 8);
        btn_go = 1'b0;
        checks++; if (soft_clr !== 1'b0) begin errors++; $display("FAIL soft_width: got %0b want 0", soft_clr); end
        step_to(s + 99);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_early: got %0b want 0", tick); end
        checks++; if (soft_cnt - sc !== 1) begin errors++; $display("FAIL soft_count: got %0d want 1", soft_cnt - sc); end
        step_to(s + 100);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %0b want 1", tick); end
        step_to(s + 101);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b want 0", tick); end
        step_to(s + 1000);
        checks++; if (time_bcd !== 8'h03) begin errors++; $display("FAIL time_pre02: got %0h want 03", time_bcd); end
        step_to(s + 1001);
        checks++; if (time_bcd !== 8'h02) begin errors++; $display("FAIL time_02: got %0h want 02", time_bcd); end
        step_to(s + 2001);
        checks++; if (time_bcd !== 8'h01) begin errors++; $display("FAIL time_01: got %0h want 01", time_bcd); end
        step_to(s + 3000);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_over_state: got %0d want 1", state); end
        checks++; if (best_bcd !== 12'h000) begin errors++; $display("FAIL pre_over_best: got %0h want 000", best_bcd); end
        step_to(s + 3001);
        checks++; if (time_bcd !== 8'h00) begin errors++; $display("FAIL time_00: got %0h want 00", time_bcd); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_state: got %0d want 3", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got %0b want 1", game_over); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL over_run: got %0b want 0", run); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL over_tick: got %0b want 0", tick); end
        checks++; if (best_bcd !== 12'h045) begin errors++; $display("FAIL best_045: got %0h want 045", best_bcd); end
        step_to(s + 3200);
        checks++; if (tick_cnt - tc !== 30) begin errors++; $display("FAIL round_ticks: got %0d want 30", tick_cnt - tc); end
        checks++; if (time_bcd !== 8'h00) begin errors++; $display("FAIL over_hold: got %0h want 00", time_bcd); end
    endtask

    task automatic test_pause();
        int s, p, r, tc, sc;
        sc = soft_cnt;
        press_go(p);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL over_to_idle: got %0d want 0", state); end
        checks++; if (time_bcd !== 8'h03) begin errors++; $display("FAIL idle_reload: got %0h want 03", time_bcd); end
        checks++; if (soft_cnt !== sc) begin errors++; $display("FAIL over_idle_soft: got %0d want %0d", soft_cnt, sc); end
        score = 12'h032;
        press_go(s);
        step_to(s + 1400);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tick4_sec2: got %0b want 1", tick); end
        checks++; if (time_bcd !== 8'h02) begin errors++; $display("FAIL sec2_time: got %0h want 02", time_bcd); end
        step_to(s + 1401);
        tc = tick_cnt;
        step_to(s + 1443);
        press_go(p);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d want 2", state); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL pause_run: got %0b want 0", run); end
        step_to(s + 1942);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_hold: got %0d want 2", state); end
        checks++; if (tick_cnt !== tc) begin errors++; $display("FAIL pause_ticks: got %0d want %0d", tick_cnt, tc); end
        checks++; if (time_bcd !== 8'h02) begin errors++; $display("FAIL pause_time: got %0h want 02", time_bcd); end
        press_go(r);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d want 1", state); end
        step_to(r + 50);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL resume_early: got %0b want 0", tick); end
        step_to(r + 51);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL resume_tick: got %0b want 1", tick); end
        step_to(r + 551);
        checks++; if (time_bcd !== 8'h02) begin errors++; $display("FAIL resume_pre01: got %0h want 02", time_bcd); end
        step_to(r + 552);
        checks++; if (time_bcd !== 8'h01) begin errors++; $display("FAIL resume_01: got %0h want 01", time_bcd); end
        step_to(r + 1552);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL r2_over: got %0d want 3", state); end
        checks++; if (best_bcd !== 12'h045) begin errors++; $display("FAIL best_keep: got %0h want 045", best_bcd); end
    endtask

    task automatic test_async_reset();
        int s, c0;
        press_go(s);
        press_go(s);
        step_to(s + 500);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL pre_rst_run: got %0b want 1", run); end
        checks++; if (best_bcd !== 12'h045) begin errors++; $display("FAIL pre_rst_best: got %0h want 045", best_bcd); end
        #3;
        clr_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d want 0", state); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL arst_run: got %0b want 0", run); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL arst_over: got %0b want 0", game_over); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL arst_tick: got %0b want 0", tick); end
        checks++; if (soft_clr !== 1'b0) begin errors++; $display("FAIL arst_soft: got %0b want 0", soft_clr); end
        checks++; if (time_bcd !== 8'h03) begin errors++; $display("FAIL arst_time: got %0h want 03", time_bcd); end
        checks++; if (best_bcd !== 12'h000) begin errors++; $display("FAIL arst_best: got %0h want 000", best_bcd); end
        step();
        btn_go = 1'b1;
        repeat (3) step();
        c0 = cyc;
        clr_n = 1'b1;
        step_to(c0 + 6);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_early: got %0d want 0", state); end
        step_to(c0 + 7);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL held_press: got %0d want 1", state); end
        checks++; if (soft_clr !== 1'b1) begin errors++; $display("FAIL held_soft: got %0b want 1", soft_clr); end
        step_to(c0 + 8);
        btn_go = 1'b0;
        step_to(c0 + 16);
        c0 = cyc;
        btn_clr = 1'b1;
        step_to(c0 + 6);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL clr_early: got %0d want 1", state); end
        step_to(c0 + 7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clr_state: got %0d want 0", state); end
        checks++; if (soft_clr !== 1'b1) begin errors++; $display("FAIL clr_soft: got %0b want 1", soft_clr); end
        step_to(c0 + 8);
        btn_clr = 1'b0;
        step_to(c0 + 16);
    endtask

    task automatic test_expiry_go();
        int s, pc;
        score = 12'h045;
        press_go(s);
        step_to(s + 2994);
        pc = pause_cnt;
        btn_go = 1'b1;
        step_to(s + 3000);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL race_pre_state: got %0d want 1", state); end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL race_tick: got %0b want 1", tick); end
        checks++; if (time_bcd !== 8'h01) begin errors++; $display("FAIL race_time01: got %0h want 01", time_bcd); end
        step_to(s + 3001);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL race_state: got %0d want 3", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL race_over: got %0b want 1", game_over); end
        checks++; if (best_bcd !== 12'h045) begin errors++; $display("FAIL race_best: got %0h want 045", best_bcd); end
        step_to(s + 3002);
        btn_go = 1'b0;
        step_to(s + 3020);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL race_hold: got %0d want 3", state); end
        checks++; if (pause_cnt !== pc) begin errors++; $display("FAIL race_paused: got %0d want %0d", pause_cnt, pc); end
    endtask

    task automatic test_best_third();
        int s;
        score = 12'h100;
        press_go(s);
        press_go(s);
        step_to(s + 3000);
        checks++; if (best_bcd !== 12'h045) begin errors++; $display("FAIL r3_pre_best: got %0h want 045", best_bcd); end
        step_to(s + 3001);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL r3_state: got %0d want 3", state); end
        checks++; if (best_bcd !== 12'h100) begin errors++; $display("FAIL best_100: got %0h want 100", best_bcd); end
    endtask

    task automatic test_glitch_both();
        int s, c0, pc, sc;
        press_go(s);
        press_go(s);
        pc = pause_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_go = 1'b1;
            repeat (3) step();
            btn_go = 1'b0;
            repeat (2) step();
        end
        repeat (10) step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_state: got %0d want 1", state); end
        checks++; if (pause_cnt !== pc) begin errors++; $display("FAIL glitch_paused: got %0d want %0d", pause_cnt, pc); end
        step_to(s + 1100);
        checks++; if (time_bcd !== 8'h02) begin errors++; $display("FAIL both_pre_time: got %0h want 02", time_bcd); end
        sc = soft_cnt;
        c0 = cyc;
        btn_go = 1'b1;
        btn_clr = 1'b1;
        step_to(c0 + 7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL both_state: got %0d want 0", state); end
        checks++; if (soft_clr !== 1'b1) begin errors++; $display("FAIL both_soft: got %0b want 1", soft_clr); end
        checks++; if (time_bcd !== 8'h03) begin errors++; $display("FAIL both_time: got %0h want 03", time_bcd); end
        checks++; if (best_bcd !== 12'h100) begin errors++; $display("FAIL both_best: got %0h want 100", best_bcd); end
        step_to(c0 + 8);
        btn_go = 1'b0;
        btn_clr = 1'b0;
        step_to(c0 + 20);
        checks++; if (soft_cnt - sc !== 1) begin errors++; $display("FAIL both_soft_cnt: got %0d want 1", soft_cnt - sc); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL both_hold: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_pause();
        test_async_reset();
        test_expiry_go();
        test_best_third();
        test_glitch_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/wam_ctl.md
# wam_ctl

Game-session controller for the Whac-A-Mole design. It debounces the start/pause and clear buttons and runs the IDLE/RUN/PAUSE/OVER state machine. It generates the gated 100 Hz game tick that clocks mole generation, hardness and tap sampling, counts down the round timer in BCD, and latches the best score. It sits upstream of the mole generator, hit and score stages, and replaces the free-running divider and toggle-pause logic in the top level.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- TICK_HZ, 100, game tick rate; CLK_HZ/TICK_HZ must be an integer ≥ 2
- GAME_SEC, 60, round length in seconds, 1..99
- DB_CYC, 500_000, clock cycles a button level must be stable to be accepted (10 ms)

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr_n  in  1  asynchronous active-low reset
- btn_go  in  1  raw start/pause button, active-high, asynchronous to clk
- btn_clr  in  1  raw clear button, active-high, asynchronous to clk
- score  in  12  current score, 3-digit BCD {hundreds, tens, ones}
- tick  out  1  one-cycle pulse at TICK_HZ, only in RUN
- run  out  1  high in RUN
- game_over  out  1  high in OVER
- soft_clr  out  1  one-cycle pulse that clears the score and hardness stages
- time_bcd  out  8  seconds remaining, 2-digit BCD
- best_bcd  out  12  best score since reset, 3-digit BCD
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3

## Operation
- Debounce, per button:
  - 2-flop synchronizer, then a stable-count of DB_CYC cycles.
  - Accepted level changes only after DB_CYC consecutive equal samples.
  - A 0→1 accepted edge produces a one-cycle press pulse (go_p, clr_p).
- FSM:
  - IDLE: go_p → RUN and pulse soft_clr.
  - RUN: go_p → PAUSE. Last second expires → OVER.
  - PAUSE: go_p → RUN. No soft_clr.
  - OVER: go_p → IDLE.
  - clr_p in any state → IDLE and pulse soft_clr. clr_p beats go_p in the same cycle.
- Tick divider:
  - Counts 0..CLK_HZ/TICK_HZ−1 only in RUN. tick is asserted on the terminal count.
  - Holds its value in PAUSE.
  - Is zeroed on entering IDLE.
- Second counter:
  - Counts ticks 0..TICK_HZ−1. On wrap, time_bcd decrements in BCD (ones 0 → 9 with a tens borrow).
  - time_bcd loads GAME_SEC (BCD) in IDLE and holds in PAUSE and OVER.
- Expiry:
  - The wrap that takes time_bcd from 01 to 00 moves the FSM to OVER in the same cycle.
  - If go_p coincides with that wrap, expiry wins (RUN→OVER, no pause).
- Best score:
  - On the RUN→OVER transition, if score > best_bcd (BCD compare, digit-wise from the MSD), best_bcd ← score.
  - Cleared only by clr_n, never by soft_clr or btn_clr.
- Outputs run, game_over and state decode directly from the state register.

## Timing
- Reset (clr_n low, async) values:
  - state=IDLE, tick=0, run=0, game_over=0, soft_clr=0.
  - time_bcd=GAME_SEC in BCD, best_bcd=000.
  - Debounced levels=0; divider and second counters=0.
- Reset released mid-press: a button already held at release is seen as a new press only after DB_CYC stable cycles.
- Button-to-press latency: 2 sync cycles + DB_CYC cycles, then go_p/clr_p for 1 cycle.
- State changes one cycle after the press pulse. soft_clr is registered and high in the same cycle that state shows the new value.
- First tick after entering RUN from IDLE arrives CLK_HZ/TICK_HZ cycles later. After a resume from PAUSE, it arrives after the remaining divider count.
- tick is never asserted in the cycle that state leaves RUN.
- time_bcd updates on the cycle after the wrapping tick. best_bcd updates in the same cycle game_over rises.

## Structure
- Package wam_pkg holds:
  - the state encoding constants (WAM_IDLE, WAM_RUN, WAM_PAUSE, WAM_OVER)
  - BCD digit width (4)
  - the score width (12)
- One sub-module, wam_dbn (synchronizer + debounce + rising-edge pulse, parameter DB_CYC), instantiated twice.
- FSM, divider, BCD countdown and best-score compare live in wam_ctl.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=10, GAME_SEC=3, DB_CYC=4.

1. Reset, then 8-cycle btn_go press → soft_clr pulses once, state=1. First tick 100 cycles later. time_bcd 03→02→01→00, one step per 10 ticks. At 00, state=3 and game_over=1.
2. score=12'h045 at expiry, then a second round ending with 12'h032 → best_bcd=045 after both. A third round ending with 12'h100 → best_bcd=100.
3. Pause at tick 4 of second 2, hold 500 cycles, resume → no ticks during PAUSE. Next tick arrives after the remaining divider count. time_bcd unchanged while paused.
4. Glitchy btn_go (3-cycle pulses, 2-cycle gaps) → no state change. btn_go and btn_clr accepted in the same cycle → state=0, soft_clr=1.
5. btn_go press timed so go_p coincides with the 01→00 wrap → state goes 1→3, never 2.
6. clr_n asserted mid-RUN with best_bcd=045 → all outputs take reset values immediately (asynchronously), including best_bcd=000.
